seven_seg_to_binary_decoder: RTL and testbench

Decodes a 7-segment pattern back into the 4-bit hex value that produced it. Seven segment lines are sampled every clock, glitches are rejected, and a result is reported only after the pattern has held steady for a programmable number of cycles. The block sits on the score-display path of the PONG design, where it reads back the segment bus for self-check and scoreboard logic. It is the inverse of the binary-to-7-segment encoder and uses the same 16-entry code table.

---
 rtl/seven_seg_to_binary_decoder_if.sv | 27 ++
 rtl/seven_seg_to_binary_decoder.sv | 144 ++++++++++++++
 tb/tb_seven_seg_to_binary_decoder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_to_binary_decoder_if.sv
// Segment bus and decoded-result signals between a segment source and the decoder.
interface seven_seg_to_binary_decoder_if;
  logic       i_SEG_0;
  logic       i_SEG_1;
  logic       i_SEG_2;
  logic       i_SEG_3;
  logic       i_SEG_4;
  logic       i_SEG_5;
  logic       i_SEG_6;
  logic [3:0] o_BINARY;
  logic       o_VALID;
  logic       o_ERROR;
  logic       o_BLANK;
  logic       o_LOCKED;

  // Segment source: drives the segment lines, observes the decode results
  modport master (
    output i_SEG_0, i_SEG_1, i_SEG_2, i_SEG_3, i_SEG_4, i_SEG_5, i_SEG_6,
    input  o_BINARY, o_VALID, o_ERROR, o_BLANK, o_LOCKED
  );

  // Decoder: samples the segment lines, produces the decode results
  modport slave (
    input  i_SEG_0, i_SEG_1, i_SEG_2, i_SEG_3, i_SEG_4, i_SEG_5, i_SEG_6,
    output o_BINARY, o_VALID, o_ERROR, o_BLANK, o_LOCKED
  );
endinterface

// File: rtl/seven_seg_to_binary_decoder.sv
// Debounced 7-segment to hex decoder: a pattern is decoded only after it has
// been sampled unchanged for STABLE_CYCLES consecutive cycles.
module seven_seg_to_binary_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                           i_CLK,
  input  logic                           i_RST,
  seven_seg_to_binary_decoder_if.slave   bus
);

  typedef enum logic {SETTLING, LOCKED} state_t;

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

  logic [6:0] seg_in;
  assign seg_in = {bus.i_SEG_6, bus.i_SEG_5, bus.i_SEG_4, bus.i_SEG_3,
                   bus.i_SEG_2, bus.i_SEG_1, bus.i_SEG_0};

  state_t     state, state_nxt;
  logic [6:0] r_SEG, seg_nxt;
  logic [7:0] r_CNT, cnt_nxt;
  logic [6:0] r_LAST, last_nxt;
  logic       r_LAST_OK, last_ok_nxt;
  logic [3:0] r_BINARY, binary_nxt;
  logic       r_VALID, valid_nxt;
  logic       r_ERROR, error_nxt;
  logic       r_BLANK, blank_nxt;
  logic       r_LOCKED, locked_nxt;

  logic       hit;
  logic [3:0] value;
  logic       accept;

  // Table lookup of the held sample ({SEG_6..SEG_0} -> hex digit)
  always_comb begin
    hit   = 1'b1;
    value = '0;
    unique case (r_SEG)
      7'b0111111: value = 4'h0;
      7'b0000110: value = 4'h1;
      7'b1011011: value = 4'h2;
      7'b1001111: value = 4'h3;
      7'b1100110: value = 4'h4;
      7'b1101101: value = 4'h5;
      7'b1111101: value = 4'h6;
      7'b0000111: value = 4'h7;
      7'b1111111: value = 4'h8;
      7'b1100111: value = 4'h9;
      7'b1110111: value = 4'hA;
      7'b1111100: value = 4'hB;
      7'b1011000: value = 4'hC;
      7'b1011110: value = 4'hD;
      7'b1111001: value = 4'hE;
      7'b1110001: value = 4'hF;
      default:    hit   = 1'b0;
    endcase
  end

  // Next state: restart on any change, count while steady, accept on lock
  always_comb begin
    state_nxt   = state;
    seg_nxt     = r_SEG;
    cnt_nxt     = r_CNT;
    last_nxt    = r_LAST;
    last_ok_nxt = r_LAST_OK;
    binary_nxt  = r_BINARY;
    valid_nxt   = 1'b0;
    error_nxt   = 1'b0;
    blank_nxt   = r_BLANK;
    locked_nxt  = r_LOCKED;
    accept      = 1'b0;

    if (seg_in != r_SEG) begin
      seg_nxt    = seg_in;
      cnt_nxt    = '0;
      state_nxt  = SETTLING;
      locked_nxt = 1'b0;
    end else begin
      unique case (state)
        SETTLING: begin
          if (r_CNT == LAST_CNT) begin
            state_nxt  = LOCKED;
            locked_nxt = 1'b1;
            accept     = 1'b1;
          end else begin
            cnt_nxt = r_CNT + 8'd1;
          end
        end
        LOCKED: ;
        default: state_nxt = SETTLING;
      endcase
    end

    // A re-lock onto the previously accepted pattern is a recovered glitch: stay silent
    if (accept && !(r_LAST_OK && (r_SEG == r_LAST))) begin
      last_nxt    = r_SEG;
      last_ok_nxt = 1'b1;
      if (hit) begin
        binary_nxt = value;
        valid_nxt  = 1'b1;
        blank_nxt  = 1'b0;
      end else if (r_SEG == '0) begin
        blank_nxt  = 1'b1;
      end else begin
        error_nxt  = 1'b1;
        blank_nxt  = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state     <= SETTLING;
      r_SEG     <= '0;
      r_CNT     <= '0;
      r_LAST    <= '0;
      r_LAST_OK <= 1'b0;
      r_BINARY  <= '0;
      r_VALID   <= 1'b0;
      r_ERROR   <= 1'b0;
      r_BLANK   <= 1'b0;
      r_LOCKED  <= 1'b0;
    end else begin
      state     <= state_nxt;
      r_SEG     <= seg_nxt;
      r_CNT     <= cnt_nxt;
      r_LAST    <= last_nxt;
      r_LAST_OK <= last_ok_nxt;
      r_BINARY  <= binary_nxt;
      r_VALID   <= valid_nxt;
      r_ERROR   <= error_nxt;
      r_BLANK   <= blank_nxt;
      r_LOCKED  <= locked_nxt;
    end
  end

  assign bus.o_BINARY = r_BINARY;
  assign bus.o_VALID  = r_VALID;
  assign bus.o_ERROR  = r_ERROR;
  assign bus.o_BLANK  = r_BLANK;
  assign bus.o_LOCKED = r_LOCKED;

endmodule

// File: tb/tb_seven_seg_to_binary_decoder.sv
// Bench for seven_seg_to_binary_decoder: two instances (STABLE_CYCLES 4 and 1)
// share the segment bus; a run-length model predicts every output each cycle.
module tb_seven_seg_to_binary_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_drv = '0;

  int tests = 0;
  int fails = 0;
  int nv = 0, ne = 0, nl = 0;

  localparam int ST [2] = '{4, 1};

  logic [6:0] codes [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
    7'b1011000, 7'b1011110, 7'b1111001, 7'b1110001};

  always #5 clk = ~clk;

  seven_seg_to_binary_decoder_if ifa ();
  seven_seg_to_binary_decoder_if ifb ();

  assign {ifa.i_SEG_6, ifa.i_SEG_5, ifa.i_SEG_4, ifa.i_SEG_3,
          ifa.i_SEG_2, ifa.i_SEG_1, ifa.i_SEG_0} = seg_drv;
  assign {ifb.i_SEG_6, ifb.i_SEG_5, ifb.i_SEG_4, ifb.i_SEG_3,
          ifb.i_SEG_2, ifb.i_SEG_1, ifb.i_SEG_0} = seg_drv;

  seven_seg_to_binary_decoder #(.STABLE_CYCLES(4)) dut_a (
    .i_CLK(clk), .i_RST(rst), .bus(ifa));
  seven_seg_to_binary_decoder #(.STABLE_CYCLES(1)) dut_b (
    .i_CLK(clk), .i_RST(rst), .bus(ifb));

  // Model: a pattern is accepted when the run of identical samples (reset
  // counts as one sample of blank) reaches STABLE_CYCLES+1.
  logic [6:0] run_val [2];
  int         run_len [2];
  logic [6:0] last    [2];
  bit         last_ok [2];
  logic [3:0] e_bin   [2];
  bit         e_v [2], e_e [2], e_bl [2], e_lk [2];
  bit         model_on = 1'b0;

  function automatic int lookup(input logic [6:0] p);
    for (int k = 0; k < 16; k++)
      if (codes[k] == p) return k;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        run_val[i] = '0; run_len[i] = 1; last_ok[i] = 1'b0; last[i] = '0;
        e_bin[i] = '0; e_v[i] = 0; e_e[i] = 0; e_bl[i] = 0; e_lk[i] = 0;
      end else begin
        e_v[i] = 0; e_e[i] = 0;
        if (seg_drv == run_val[i]) begin
          if (run_len[i] < 1000) run_len[i]++;
        end else begin
          run_val[i] = seg_drv;
          run_len[i] = 1;
        end
        e_lk[i] = (run_len[i] >= ST[i] + 1);
        if (run_len[i] == ST[i] + 1 && !(last_ok[i] && run_val[i] == last[i])) begin
          int idx;
          last[i] = run_val[i];
          last_ok[i] = 1'b1;
          idx = lookup(run_val[i]);
          if (idx >= 0) begin
            e_bin[i] = 4'(idx); e_v[i] = 1; e_bl[i] = 0;
          end else if (run_val[i] == 7'd0) begin
            e_bl[i] = 1;
          end else begin
            e_e[i] = 1; e_bl[i] = 0;
          end
        end
      end
    end
    if (rst) model_on = 1'b1;
  end

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (model_on) begin
      logic [7:0] act [2];
      logic [7:0] exp;
      act[0] = {ifa.o_BINARY, ifa.o_VALID, ifa.o_ERROR, ifa.o_BLANK, ifa.o_LOCKED};
      act[1] = {ifb.o_BINARY, ifb.o_VALID, ifb.o_ERROR, ifb.o_BLANK, ifb.o_LOCKED};
      for (int i = 0; i < 2; i++) begin
        exp = {e_bin[i], e_v[i], e_e[i], e_bl[i], e_lk[i]};
        tests++;
        if (act[i] !== exp) begin
          fails++;
          $display("FAIL model_dut%0d @%0t: {bin,v,e,bl,lk} got %b expected %b",
                   i, $time, act[i], exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ifa.o_VALID === 1'b1)  nv++;
    if (ifa.o_ERROR === 1'b1)  ne++;
    if (ifa.o_LOCKED === 1'b1) nl++;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_drv = p;
    repeat (n) tick();
  endtask

  initial begin
    // Reset, then hold code 2
    rst = 1'b1;
    seg_drv = codes[2];
    tick();
    chk("reset_outs_a", int'({ifa.o_BINARY, ifa.o_VALID, ifa.o_ERROR, ifa.o_BLANK, ifa.o_LOCKED}), 0);
    chk("reset_outs_b", int'({ifb.o_BINARY, ifb.o_VALID, ifb.o_ERROR, ifb.o_BLANK, ifb.o_LOCKED}), 0);
    rst = 1'b0;
    tick(); tick();
    chk("st1_valid_edge2", int'(ifb.o_VALID), 1);
    chk("st1_binary", int'(ifb.o_BINARY), 2);
    tick(); tick();
    chk("st4_no_valid_edge4", int'(ifa.o_VALID), 0);
    tick();
    chk("st4_valid_edge5", int'(ifa.o_VALID), 1);
    chk("st4_binary_2", int'(ifa.o_BINARY), 2);
    chk("st4_locked", int'(ifa.o_LOCKED), 1);
    tick();
    chk("valid_one_cycle", int'(ifa.o_VALID), 0);

    // Sweep every code
    nv = 0; ne = 0;
    for (int c = 0; c < 16; c++) hold(codes[c], 8);
    chk("sweep_valid_count", nv, 16);
    chk("sweep_error_count", ne, 0);
    chk("sweep_last_binary", int'(ifa.o_BINARY), 15);

    // Glitch that returns to the prior code
    hold(codes[1], 8);
    nv = 0;
    hold(codes[8], 2);
    chk("glitch_unlocked", int'(ifa.o_LOCKED), 0);
    hold(codes[1], 8);
    chk("glitch_no_valid", nv, 0);
    chk("glitch_binary_1", int'(ifa.o_BINARY), 1);
    chk("glitch_relocked", int'(ifa.o_LOCKED), 1);

    // Illegal pattern, then blank
    nv = 0; ne = 0;
    hold(7'b1010101, 8);
    chk("illegal_error_pulse", ne, 1);
    chk("illegal_no_valid", nv, 0);
    chk("illegal_binary_kept", int'(ifa.o_BINARY), 1);
    chk("illegal_blank_low", int'(ifa.o_BLANK), 0);
    ne = 0;
    hold(7'b0000000, 8);
    chk("blank_high", int'(ifa.o_BLANK), 1);
    chk("blank_no_error", ne, 0);
    chk("blank_no_valid", nv, 0);

    // Toggle faster than the stability window
    nv = 0; nl = 0;
    for (int k = 0; k < 8; k++) hold((k % 2) ? codes[5] : codes[3], 3);
    chk("toggle_no_valid", nv, 0);
    chk("toggle_never_locked", nl, 0);

    // Reset while code 3 is settling
    hold(codes[3], 2);
    rst = 1'b1;
    tick();
    chk("midreset_outs", int'({ifa.o_BINARY, ifa.o_VALID, ifa.o_ERROR, ifa.o_BLANK, ifa.o_LOCKED}), 0);
    rst = 1'b0;
    repeat (4) tick();
    chk("midreset_no_early_valid", int'(ifa.o_VALID), 0);
    tick();
    chk("midreset_valid_edge5", int'(ifa.o_VALID), 1);
    chk("midreset_binary_3", int'(ifa.o_BINARY), 3);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
